// File: rtl/polyphase_sched_if.sv
// ---------------------------------------------------------------------------
// polyphase_sched_if
//
// Purpose:
//    Bundles the control, phase-filter and output-handshake signals of the
//    polyphase decimation scheduler.  The scheduler connects through the
//    slave modport.  Whatever drives it (controller plus phase filters, or a
//    testbench) connects through the master modport.
//
// Parameters:
//    PHASE_NUM  number of polyphase branches (power of two)
//    PHASE_BIT  log2(PHASE_NUM)
//    IN_W       signed width of one phase-filter output
//    OUT_W      signed width of the decimated output
//
// Signals (direction seen from the scheduler):
//    start      in   request to begin decimation
//    stop       in   request to end decimation after the current frame
//    phase_en   out  one-hot clock enable for the phase filters
//    phase_sel  out  index of the enabled phase (external result mux select)
//    phase_y    in   signed output of the selected phase, one cycle after enable
//    out_data   out  signed decimated sample
//    out_valid  out  output sample valid
//    out_ready  in   downstream ready for the output sample
//    busy       out  scheduler is not idle
//    overrun    out  sticky flag: an unconsumed output sample was overwritten
// ---------------------------------------------------------------------------
interface polyphase_sched_if #(
   parameter int PHASE_NUM = 8,
   parameter int PHASE_BIT = 3,
   parameter int IN_W      = 20,
   parameter int OUT_W     = 8
);

   logic                 start;
   logic                 stop;
   logic [PHASE_NUM-1:0] phase_en;
   logic [PHASE_BIT-1:0] phase_sel;
   logic [IN_W-1:0]      phase_y;
   logic [OUT_W-1:0]     out_data;
   logic                 out_valid;
   logic                 out_ready;
   logic                 busy;
   logic                 overrun;

   // The scheduler side: consumes control and phase results, produces enables
   // and the decimated output stream.
   modport slave (
      input  start,
      input  stop,
      input  phase_y,
      input  out_ready,
      output phase_en,
      output phase_sel,
      output out_data,
      output out_valid,
      output busy,
      output overrun
   );

   // The environment side: mirror image of the slave modport.
   modport master (
      output start,
      output stop,
      output phase_y,
      output out_ready,
      input  phase_en,
      input  phase_sel,
      input  out_data,
      input  out_valid,
      input  busy,
      input  overrun
   );

endinterface

// File: rtl/polyphase_sched.sv
// ---------------------------------------------------------------------------
// polyphase_sched
//
// Purpose:
//    Time-multiplexed scheduler for a polyphase decimator.  While running it
//    enables one phase filter per cycle (0 .. PHASE_NUM-1, repeating).  It
//    collects each phase result one cycle after its enable and adds up a
//    full frame of PHASE_NUM results.  It then narrows the frame sum to OUT_W
//    bits and presents it on a valid/ready output port.  A stop request lets
//    the current frame finish before the block returns to idle.
//
// Parameters:
//    PHASE_NUM  number of polyphase branches (power of two)
//    PHASE_BIT  log2(PHASE_NUM)
//    IN_W       signed width of one phase-filter output
//    OUT_W      signed width of the decimated output
//
// Ports:
//    clk        single system clock, rising edge
//    reset      synchronous, active-high reset
//    bus        polyphase_sched_if.slave: start/stop control, phase_en and
//               phase_sel to the phase filters, phase_y back from them,
//               out_data/out_valid/out_ready output handshake, busy and
//               the sticky overrun flag
//
// Build option:
//    POLYPHASE_SCHED_SAT_EN  when defined, the narrowed output saturates to
//                            the OUT_W signed range.  When undefined (the
//                            default), the discarded upper bits are simply
//                            dropped, so an out-of-range sum wraps.
// ---------------------------------------------------------------------------
module polyphase_sched #(
   parameter int PHASE_NUM = 8,
   parameter int PHASE_BIT = 3,
   parameter int IN_W      = 20,
   parameter int OUT_W     = 8
) (
   input logic              clk,
   input logic              reset,
   polyphase_sched_if.slave bus
);

   localparam int                   ACC_W      = IN_W + PHASE_BIT;
   localparam logic [PHASE_BIT-1:0] LAST_PHASE = PHASE_BIT'(PHASE_NUM - 1);
   localparam logic [PHASE_NUM-1:0] ONE_HOT0   = {{(PHASE_NUM-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FLUSH
   } state_t;

   state_t                   r_state;
   state_t                   w_stateNext;
   logic [PHASE_BIT-1:0]     r_cnt;
   logic [PHASE_BIT-1:0]     w_cntNext;
   logic                     r_enAct;
   logic                     w_enActNext;

   logic                     r_capVld;
   logic [PHASE_BIT-1:0]     r_capIdx;

   logic signed [ACC_W-1:0]  r_acc;
   logic signed [ACC_W-1:0]  w_ySext;
   logic signed [ACC_W-1:0]  w_sum;
   logic [OUT_W-1:0]         w_narrow;
   logic                     w_load;

   logic [OUT_W-1:0]         r_outData;
   logic                     r_outValid;
   logic                     r_overrun;

   logic [PHASE_NUM-1:0]     w_phaseEn;

   // State, phase counter and enable-active register.  r_enAct marks the
   // cycles in which phase r_cnt is really enabled.  This allows RUN to begin
   // with one quiet cycle, so phase 0 appears on the cycle after RUN is
   // entered.  It also lets FLUSH stop issuing enables once the frame ends.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_enAct <= 1'b0;
      end else begin
         r_state <= w_stateNext;
         r_cnt   <= w_cntNext;
         r_enAct <= w_enActNext;
      end
   end

   // Next-state logic.  A frame that has begun is always finished.  If stop
   // arrives while phase PHASE_NUM-1 is enabled, that enable closes the frame.
   // If stop arrives before phase 0 was ever enabled, no frame is started.
   // FLUSH waits until enables have ceased.  The capture of the final phase
   // happens during that wait cycle, so the return to IDLE lines up with the
   // output load.  start is looked at only in IDLE, and stop overrides it
   // there.
   always_comb begin
      w_stateNext = r_state;
      w_cntNext   = r_cnt;
      w_enActNext = r_enAct;
      case (r_state)
         IDLE: begin
            w_cntNext   = '0;
            w_enActNext = 1'b0;
            if (bus.start && !bus.stop) begin
               w_stateNext = RUN;
            end
         end
         RUN: begin
            if (bus.stop) begin
               w_stateNext = FLUSH;
            end
            if (r_enAct) begin
               w_cntNext = r_cnt + 1'b1;
               if (bus.stop && (r_cnt == LAST_PHASE)) begin
                  w_enActNext = 1'b0;
                  w_cntNext   = '0;
               end
            end else if (!bus.stop) begin
               w_enActNext = 1'b1;
            end
         end
         FLUSH: begin
            if (r_enAct) begin
               if (r_cnt == LAST_PHASE) begin
                  w_enActNext = 1'b0;
                  w_cntNext   = '0;
               end else begin
                  w_cntNext = r_cnt + 1'b1;
               end
            end else begin
               w_stateNext = IDLE;
            end
         end
         default: begin
            w_stateNext = IDLE;
            w_cntNext   = '0;
            w_enActNext = 1'b0;
         end
      endcase
   end

   // One-hot phase enable, all zero whenever no phase is active.
   assign w_phaseEn = r_enAct ? (ONE_HOT0 << r_cnt) : '0;

   // Capture pipeline: the filter result for an enable arrives one cycle
   // later, so the enable flag and the phase index are delayed to match it.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_capVld <= 1'b0;
         r_capIdx <= '0;
      end else begin
         r_capVld <= r_enAct;
         r_capIdx <= r_cnt;
      end
   end

   // Frame sum.  Phase 0 starts a new sum, so no explicit clear is needed
   // between frames.  A sum whose frame was cut off by reset is never reused.
   assign w_ySext = {{PHASE_BIT{bus.phase_y[IN_W-1]}}, bus.phase_y};
   assign w_sum   = (r_capIdx == '0) ? w_ySext : (r_acc + w_ySext);
   assign w_load  = r_capVld && (r_capIdx == LAST_PHASE);

   // The accumulator only moves on real capture cycles.  At all other times
   // phase_y carries no meaning.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_acc <= '0;
      end else if (r_capVld) begin
         r_acc <= w_sum;
      end
   end

`ifdef POLYPHASE_SCHED_SAT_EN
   // Saturating narrow.  The sum fits in OUT_W bits after the shift only if
   // every bit from the MSB down to IN_W-1 has the same value.  Otherwise the
   // output is clamped to the signed extreme given by the sign bit.
   always_comb begin
      w_narrow = w_sum[IN_W-1 -: OUT_W];
      if (!(&w_sum[ACC_W-1:IN_W-1]) && (|w_sum[ACC_W-1:IN_W-1])) begin
         if (w_sum[ACC_W-1]) begin
            w_narrow = {1'b1, {(OUT_W-1){1'b0}}};
         end else begin
            w_narrow = {1'b0, {(OUT_W-1){1'b1}}};
         end
      end
   end
`else
   // Wrapping narrow: arithmetic shift right by IN_W-OUT_W.  Only the OUT_W
   // bits below the guard bits are kept.
   assign w_narrow = w_sum[IN_W-1 -: OUT_W];
`endif

   // Output register and handshake.  A new sample always wins, even if the
   // previous one has not been taken.  Losing an untaken sample sets the sticky
   // overrun flag.  A sample that is taken on the same cycle the next one is
   // loaded counts as consumed, not lost.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_outData  <= '0;
         r_outValid <= 1'b0;
         r_overrun  <= 1'b0;
      end else begin
         if (w_load) begin
            r_outData  <= w_narrow;
            r_outValid <= 1'b1;
            if (r_outValid && !bus.out_ready) begin
               r_overrun <= 1'b1;
            end
         end else if (r_outValid && bus.out_ready) begin
            r_outValid <= 1'b0;
         end
      end
   end

   assign bus.phase_en  = w_phaseEn;
   assign bus.phase_sel = r_cnt;
   assign bus.out_data  = r_outData;
   assign bus.out_valid = r_outValid;
   assign bus.busy      = (r_state != IDLE);
   assign bus.overrun   = r_overrun;

endmodule
